// File: rtl/demux_router_if.sv
// -----------------------------------------------------------------------------
// demux_router_if
// Handshake bundle for demux_router: one source stream (data/select/valid,
// ready back) and two destination channels A and B (data/valid out, ready
// in, plus occupancy).
//   slave  : seen by the router (consumes the source, drives the channels)
//   master : seen by the environment (drives the source and channel readies)
// -----------------------------------------------------------------------------
interface demux_router_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
);
   logic [WIDTH-1:0]         in_data;
   logic                     in_sel;
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         a_data;
   logic                     a_valid;
   logic                     a_ready;
   logic [WIDTH-1:0]         b_data;
   logic                     b_valid;
   logic                     b_ready;
   logic [$clog2(DEPTH):0]   a_count;
   logic [$clog2(DEPTH):0]   b_count;

   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
   );

   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
   );
endinterface

// File: rtl/demux_router.sv
// -----------------------------------------------------------------------------
// demux_router
// Steers one WIDTH-bit source stream into channel A (in_sel=0) or channel B
// (in_sel=1). Each channel owns a DEPTH-entry circular FIFO with its own
// valid/ready handshake, so a stalled consumer never blocks the other one.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears pointers, counts, storage)
//   bus  : demux_router_if.slave (source + channels A/B, see interface)
// Optional build macro DEMUX_ROUTER_STATS_EN adds 16-bit wrapping counters:
//   a_xfers, b_xfers : completed output handshakes per channel
//   stall_cycles     : cycles with in_valid=1 and in_ready=0
// WIDTH/DEPTH must match the parameters of the connected interface.
// -----------------------------------------------------------------------------

// One channel FIFO. Head data is read straight from storage, so a word
// written at an edge is visible the following cycle and never earlier.
module demux_router_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // NOTE: storage is deliberately included in the reset so the head reads
   // back a defined zero after reset; this is cheap only because DEPTH is tiny.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;   // power-of-two depth wraps for free
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;                      // idle or push+pop: occupancy unchanged
         endcase
      end
   end

   assign head = mem[rd_ptr];
   assign full = (count == CW'(DEPTH));
endmodule

module demux_router #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   demux_router_if.slave      bus
`ifdef DEMUX_ROUTER_STATS_EN
   ,
   output logic [15:0]        a_xfers,
   output logic [15:0]        b_xfers,
   output logic [15:0]        stall_cycles
`endif
);
   logic full_a, full_b;
   logic push_a, push_b;
   logic pop_a, pop_b;

   // Readiness depends only on the selected FIFO's registered full flag; a
   // same-cycle pop does not make a full channel writable.
   assign bus.in_ready = bus.in_sel ? ~full_b : ~full_a;

   assign push_a = bus.in_valid && bus.in_ready && !bus.in_sel;
   assign push_b = bus.in_valid && bus.in_ready &&  bus.in_sel;

   // Popping an empty channel is masked here, so x_ready is ignored when empty.
   assign pop_a  = bus.a_valid && bus.a_ready;
   assign pop_b  = bus.b_valid && bus.b_ready;

   assign bus.a_valid = (bus.a_count != '0);
   assign bus.b_valid = (bus.b_count != '0);

   demux_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk   (clk),
      .rst   (rst),
      .push  (push_a),
      .wdata (bus.in_data),
      .pop   (pop_a),
      .head  (bus.a_data),
      .count (bus.a_count),
      .full  (full_a)
   );

   demux_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .rst   (rst),
      .push  (push_b),
      .wdata (bus.in_data),
      .pop   (pop_b),
      .head  (bus.b_data),
      .count (bus.b_count),
      .full  (full_b)
   );

`ifdef DEMUX_ROUTER_STATS_EN
   // Free-running 16-bit counters; natural overflow gives the 0xFFFF->0 wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_xfers      <= '0;
         b_xfers      <= '0;
         stall_cycles <= '0;
      end else begin
         if (pop_a) a_xfers <= a_xfers + 16'd1;
         if (pop_b) b_xfers <= b_xfers + 16'd1;
         if (bus.in_valid && !bus.in_ready) stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_demux_router.sv
// -----------------------------------------------------------------------------
// tb_demux_router
// Directed bench for demux_router. A queue-based model of the two channels
// predicts every output; a compare process checks the DUT against it on each
// falling edge, and hand-computed literals pin the model at key points.
// Inputs change 1 time unit after the falling edge; the DUT samples on the
// rising edge. Build with DEMUX_ROUTER_STATS_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_demux_router;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   demux_router_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef DEMUX_ROUTER_STATS_EN
   logic [15:0] a_xfers, b_xfers, stall_cycles;
`endif

   demux_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DEMUX_ROUTER_STATS_EN
      ,
      .a_xfers      (a_xfers),
      .b_xfers      (b_xfers),
      .stall_cycles (stall_cycles)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   int xa = 0, xb = 0, st = 0;

   function automatic bit model_ready();
      return bus.in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         qa.delete();
         qb.delete();
         xa = 0;
         xb = 0;
         st = 0;
      end else begin
         bit rdy, pa, pb, oa, ob;
         rdy = model_ready();
         pa  = bus.in_valid && rdy && !bus.in_sel;
         pb  = bus.in_valid && rdy &&  bus.in_sel;
         oa  = bus.a_ready && (qa.size() > 0);
         ob  = bus.b_ready && (qb.size() > 0);
         if (oa) begin void'(qa.pop_front()); xa++; end
         if (ob) begin void'(qb.pop_front()); xb++; end
         if (pa) qa.push_back(bus.in_data);
         if (pb) qb.push_back(bus.in_data);
         if (bus.in_valid && !rdy) st++;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
         check("a_valid",  32'(bus.a_valid),  32'(qa.size() != 0));
         check("b_valid",  32'(bus.b_valid),  32'(qb.size() != 0));
         check("a_count",  32'(bus.a_count),  32'(qa.size()));
         check("b_count",  32'(bus.b_count),  32'(qb.size()));
         if (qa.size() != 0) check("a_data", 32'(bus.a_data), 32'(qa[0]));
         if (qb.size() != 0) check("b_data", 32'(bus.b_data), 32'(qb[0]));
`ifdef DEMUX_ROUTER_STATS_EN
         check("a_xfers",      32'(a_xfers),      32'(xa & 16'hFFFF));
         check("b_xfers",      32'(b_xfers),      32'(xb & 16'hFFFF));
         check("stall_cycles", 32'(stall_cycles), 32'(st & 16'hFFFF));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   // Present one set of inputs; they are sampled at the next rising edge.
   task automatic cyc(input bit v, input bit s, input logic [7:0] d,
                      input bit ar, input bit br);
      @(negedge clk);
      #1;
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
      bus.a_ready  = ar;
      bus.b_ready  = br;
   endtask

   // Let the pending inputs be sampled, then look at the post-edge state.
   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = '0;
      bus.a_ready  = 1'b0;
      bus.b_ready  = 1'b0;

      // Reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst a_valid", 32'(bus.a_valid), 32'd0);
      check("rst b_valid", 32'(bus.b_valid), 32'd0);
      check("rst a_count", 32'(bus.a_count), 32'd0);
      check("rst b_count", 32'(bus.b_count), 32'd0);
      check("rst a_data",  32'(bus.a_data),  32'd0);
      check("rst in_ready sel0", 32'(bus.in_ready), 32'd1);
      bus.in_sel = 1'b1;
      #1 check("rst in_ready sel1", 32'(bus.in_ready), 32'd1);

      // Single push to A, then one pop
      cyc(1, 0, 8'h3C, 0, 0);
      settle();
      check("push a_valid", 32'(bus.a_valid), 32'd1);
      check("push a_data",  32'(bus.a_data),  32'h3C);
      check("push a_count", 32'(bus.a_count), 32'd1);
      check("push b_valid", 32'(bus.b_valid), 32'd0);
      cyc(0, 0, 8'h00, 1, 0);
      settle();
      check("pop a_valid", 32'(bus.a_valid), 32'd0);
      check("pop a_count", 32'(bus.a_count), 32'd0);

      // Fill B, B stalls while A stays writable, then drain B in order
      cyc(1, 1, 8'h11, 0, 0);
      cyc(1, 1, 8'h22, 0, 0);
      cyc(1, 1, 8'h33, 0, 0);
      settle();
      check("B full in_ready", 32'(bus.in_ready), 32'd0);
      check("B full count",    32'(bus.b_count),  32'd2);
      check("B head 0x11",     32'(bus.b_data),   32'h11);
      cyc(1, 0, 8'h55, 0, 0);
      settle();
      check("A while B full count", 32'(bus.a_count), 32'd1);
      check("A while B full data",  32'(bus.a_data),  32'h55);
      check("B untouched count",    32'(bus.b_count), 32'd2);
      cyc(0, 0, 8'h00, 1, 1);
      settle();
      check("B drain head 0x22", 32'(bus.b_data),  32'h22);
      check("B drain count",     32'(bus.b_count), 32'd1);
      cyc(0, 0, 8'h00, 1, 1);
      settle();
      check("B drained valid", 32'(bus.b_valid), 32'd0);

      // Wrap-around with a pop every cycle
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 0, 8'(i), 1, 0);
         settle();
         check("wrap a_data",  32'(bus.a_data),  32'(i));
         check("wrap a_count", 32'(bus.a_count), 32'd1);
      end
      cyc(0, 0, 8'h00, 1, 0);
      settle();
      check("wrap empty", 32'(bus.a_count), 32'd0);

      // Full channel with same-cycle pop: push rejected, retried next cycle
      cyc(1, 0, 8'hAA, 0, 0);
      cyc(1, 0, 8'hBB, 0, 0);
      settle();
      check("A full count", 32'(bus.a_count), 32'd2);
      cyc(1, 0, 8'hCC, 1, 0);
      check("full no-pass in_ready", 32'(bus.in_ready), 32'd0);
      settle();
      check("full pop count", 32'(bus.a_count), 32'd1);
      check("full pop head",  32'(bus.a_data),  32'hBB);
      check("retry in_ready", 32'(bus.in_ready), 32'd1);
      settle();
      check("retry count", 32'(bus.a_count), 32'd1);
      check("retry head",  32'(bus.a_data),  32'hCC);
      cyc(0, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 0, 0);

      // Asynchronous reset between edges with A full
      cyc(1, 0, 8'hD1, 0, 0);
      cyc(1, 0, 8'hD2, 0, 0);
      settle();
      check("pre-rst a_count", 32'(bus.a_count), 32'd2);
      @(negedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("async rst a_valid", 32'(bus.a_valid), 32'd0);
      check("async rst a_count", 32'(bus.a_count), 32'd0);
      @(negedge clk);
      #1 rst = 1'b0;

      // Counter scenario: 4 stalls, then 3 A pops and 1 B pop
      cyc(1, 0, 8'h01, 0, 0);
      cyc(1, 0, 8'h02, 0, 0);
      repeat (4) cyc(1, 0, 8'h03, 0, 0);
      cyc(1, 1, 8'h09, 0, 0);
      cyc(0, 0, 8'h00, 1, 1);
      cyc(1, 0, 8'h03, 1, 0);
      cyc(0, 0, 8'h00, 1, 0);
      settle();
      check("stats a_count", 32'(bus.a_count), 32'd0);
      check("stats b_count", 32'(bus.b_count), 32'd0);
`ifdef DEMUX_ROUTER_STATS_EN
      check("a_xfers literal",      32'(a_xfers),      32'd3);
      check("b_xfers literal",      32'(b_xfers),      32'd1);
      check("stall_cycles literal", 32'(stall_cycles), 32'd4);
`endif
      cyc(0, 0, 8'h00, 0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Inverse of the datapath 2:1 select: one 8-bit source stream is steered by a select bit to one of two destination channels, A (sel=0) or B (sel=1).
- Each channel has its own small FIFO and a valid/ready handshake, so a stalled destination does not block traffic to the other.
- Sits between the ALU/load result bus and two downstream consumers (e.g. register-file write port and output port).

Parameters:
- WIDTH, 8, data width of source and both channels.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  source data.
- in_sel  input  1  destination select: 0 = channel A, 1 = channel B.
- in_valid  input  1  source offers a word this cycle.
- in_ready  output  1  selected channel can accept; combinational from in_sel and FIFO full flags.
- a_data  output  WIDTH  channel A head-of-FIFO data.
- a_valid  output  1  channel A FIFO non-empty.
- a_ready  input  1  channel A consumer accepts.
- b_data  output  WIDTH  channel B head-of-FIFO data.
- b_valid  output  1  channel B FIFO non-empty.
- b_ready  input  1  channel B consumer accepts.
- a_count  output  log2(DEPTH)+1  channel A occupancy.
- b_count  output  log2(DEPTH)+1  channel B occupancy.

Behaviour:
- Reset (async, rst=1):
  - Pointers and counts go to 0, storage goes to 0.
  - a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0.
  - Takes effect immediately, mid-transfer included; in-flight words are discarded.
- Input transfer occurs when in_valid && in_ready.
  - in_ready = ~full_A when in_sel=0, ~full_B when in_sel=1.
  - in_sel is sampled only on a transfer cycle.
  - Source must hold in_data/in_sel stable while in_valid=1 and in_ready=0.
- Output transfer occurs when x_valid && x_ready. Head advances on the clock edge; next entry is visible on x_data the following cycle.
- Latency: a word written into an empty FIFO appears on x_data with x_valid=1 one cycle after the accepting edge. No combinational pass-through.
- Each channel is an independent circular FIFO:
  - Write and read pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
  - full = (count==DEPTH), empty = (count==0).
- Full channel: in_ready=0 for that select, even if the same-cycle pop would free a slot (no full-pass). The other channel remains writable.
- Empty channel: x_valid=0, x_data holds last-read storage content (don't-care), and x_ready has no effect.
- Simultaneous push to A and pop from B: both occur, with no interaction.
- x_valid is registered-derived (from count), never combinational from inputs.

Optional Feature:
- Macro: DEMUX_ROUTER_STATS_EN.
- When defined:
  - Adds outputs a_xfers, b_xfers (16 bits each) and stall_cycles (16 bits), all reset to 0.
  - a_xfers/b_xfers count completed output handshakes per channel.
  - stall_cycles counts cycles with in_valid=1 and in_ready=0.
  - All three wrap 0xFFFF -> 0x0000.
- When undefined: these ports and counters are absent; core behaviour is unchanged.

Test Plan:
- Reset then idle: rst pulse -> a_valid=b_valid=0, a_count=b_count=0, in_ready=1 for both sel values.
- Push 0x3C sel=0 with a_ready=0 -> next cycle a_valid=1, a_data=0x3C, a_count=1, b_valid=0; then a_ready=1 for one cycle -> a_valid=0, a_count=0.
- Fill B with 0x11 and 0x22 (b_ready=0):
  - in_sel=1 -> in_ready=0 and B is unchanged.
  - in_sel=0 with 0x55 -> accepted into A.
  - Drain B -> 0x11 then 0x22, in order.
- Wrap-around: push 5 words 0x01..0x05 to A while popping every cycle -> outputs 0x01..0x05 in order, a_count never exceeds 2.
- Full with same-cycle pop: A full, a_ready=1, in_valid=1, sel=0 -> push rejected that cycle (in_ready=0), a_count drops to 1, push accepted next cycle.
- Async reset mid-stream: assert rst between edges with A count=2 -> a_valid=0 and a_count=0 immediately, without waiting for a clock edge.
- With DEMUX_ROUTER_STATS_EN defined: 3 A pops, 1 B pop, 4 stalled cycles -> a_xfers=3, b_xfers=1, stall_cycles=4.
